// File: rtl/reg_file_pkg.sv
// Shared register-file constants. WB and decode import these too,
// so they agree on the call destination and the stack pointer.
package reg_file_pkg;
    localparam int REG_ADDR_W    = 4;
    localparam int REG_DATA_W    = 32;
    localparam int NUM_ARCH_REGS = 16;

    localparam logic [3:0]  RA_IDX           = 4'd15;
    localparam logic [3:0]  SP_IDX           = 4'd14;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_FFFC;

    localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;
endpackage

// File: rtl/reg_file_bypass_mux.sv
// Read-port select: stored value, or the write-back data when the same
// register is being written this cycle and bypass is enabled.
module reg_file_bypass_mux #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd_data
);
    logic hit;

    always_comb begin
        hit = WB_BYPASS && wb_en && (wb_addr == rd_addr);
        rd_data = hit ? wb_data : stored_data;
    end
endmodule

// File: rtl/reg_file.sv
// Architectural register file: one write port from WB, two operand read
// ports plus a dedicated r15 return-address port, all combinational.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int          NUM_REGS  = NUM_ARCH_REGS,
    parameter int          ADDR_W    = REG_ADDR_W,
    parameter int          DATA_W    = REG_DATA_W,
    parameter bit          WB_BYPASS = 1'b1,
    parameter logic [31:0] SP_RESET  = SP_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] ra_data,
    output logic [15:0]       wr_count
);
    localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_IDX);
    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    // No handshake: WB owns timing and one write is accepted every cycle.
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
            if (wr_count_q != WR_COUNT_MAX) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == int'(SP_ADDR)) ? DATA_W'(SP_RESET) : '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    reg_file_bypass_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_BYPASS(WB_BYPASS)) u_mux_rd1 (
        .rd_addr     (rd_addr1),
        .stored_data (regs_q[rd_addr1]),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_data     (rd_data1)
    );

    reg_file_bypass_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_BYPASS(WB_BYPASS)) u_mux_rd2 (
        .rd_addr     (rd_addr2),
        .stored_data (regs_q[rd_addr2]),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_data     (rd_data2)
    );

    reg_file_bypass_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_BYPASS(WB_BYPASS)) u_mux_ra (
        .rd_addr     (RA_ADDR),
        .stored_data (regs_q[RA_ADDR]),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_data     (ra_data)
    );

    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: the driver queues expected outputs for the
// current cycle, and a negedge monitor drains and compares them.
module tb_reg_file;
    localparam bit WB_BYPASS = 1'b1;

    localparam int SEL_RD1 = 0;
    localparam int SEL_RD2 = 1;
    localparam int SEL_RA  = 2;
    localparam int SEL_CNT = 3;

    logic        clk;
    logic        reset;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] ra_data;
    logic [15:0] wr_count;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];

    int n_cmp;
    int n_err;

    logic [31:0] model [16];

    reg_file #(.WB_BYPASS(WB_BYPASS)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .ra_data  (ra_data),
        .wr_count (wr_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive(input logic en, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] a1, input logic [3:0] a2);
        wb_en    = en;
        wb_addr  = wa;
        wb_data  = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
    endtask

    task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: everything queued this cycle is checked at negedge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] act;
            int          s;
            string       nm;
            e  = exp_q.pop_front();
            s  = sel_q.pop_front();
            nm = name_q.pop_front();
            case (s)
                SEL_RD1: act = rd_data1;
                SEL_RD2: act = rd_data2;
                SEL_RA:  act = ra_data;
                default: act = {16'h0, wr_count};
            endcase
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %08h expected %08h", nm, act, e);
            end
        end
    end

    initial begin
        logic [31:0] d;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
        step();
        step();
        reset = 1'b0;

        // reset contents across all indices
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'(i);
            b = 4'(15 - i);
            drive(1'b0, 4'd0, 32'h0, a, b);
            expect_out(SEL_RD1, (a == 4'd14) ? 32'h0000_FFFC : 32'h0, $sformatf("reset_rd1_r%0d", i));
            expect_out(SEL_RD2, (b == 4'd14) ? 32'h0000_FFFC : 32'h0, $sformatf("reset_rd2_r%0d", 15 - i));
            if (i == 0) begin
                expect_out(SEL_RA, 32'h0, "reset_ra");
                expect_out(SEL_CNT, 32'h0, "reset_wr_count");
            end
            step();
        end

        // basic write / read
        drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'd0, 4'd1);
        expect_out(SEL_RD1, 32'h0, "wr3_rd_r0_unaffected");
        step();
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd2);
        expect_out(SEL_RD1, 32'hDEAD_BEEF, "wr3_readback");
        expect_out(SEL_RD2, 32'h0, "wr3_r2_unaffected");
        expect_out(SEL_CNT, 32'd1, "wr3_count");
        step();

        // same-cycle bypass on both ports
        drive(1'b1, 4'd5, 32'h1234_5678, 4'd5, 4'd5);
        expect_out(SEL_RD1, WB_BYPASS ? 32'h1234_5678 : 32'h0, "bypass_rd1");
        expect_out(SEL_RD2, WB_BYPASS ? 32'h1234_5678 : 32'h0, "bypass_rd2");
        expect_out(SEL_CNT, 32'd1, "bypass_count_before_edge");
        step();
        drive(1'b0, 4'd5, 32'h0, 4'd5, 4'd5);
        expect_out(SEL_RD1, 32'h1234_5678, "r5_stored_rd1");
        expect_out(SEL_RD2, 32'h1234_5678, "r5_stored_rd2");
        expect_out(SEL_CNT, 32'd2, "r5_count");
        step();

        // call writes r15
        drive(1'b1, 4'd15, 32'h0000_0104, 4'd15, 4'd3);
        expect_out(SEL_RA, WB_BYPASS ? 32'h0000_0104 : 32'h0, "call_ra_bypass");
        expect_out(SEL_RD1, WB_BYPASS ? 32'h0000_0104 : 32'h0, "call_rd1_bypass");
        expect_out(SEL_RD2, 32'hDEAD_BEEF, "call_rd2_other");
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd15);
            expect_out(SEL_RA, 32'h0000_0104, $sformatf("call_ra_hold%0d", i));
            expect_out(SEL_RD2, 32'h0000_0104, $sformatf("call_rd2_hold%0d", i));
            expect_out(SEL_CNT, 32'd3, $sformatf("call_count%0d", i));
            step();
        end

        // disabled write must neither bypass nor store
        drive(1'b0, 4'd7, 32'hFFFF_FFFF, 4'd7, 4'd7);
        expect_out(SEL_RD1, 32'h0, "disabled_no_bypass");
        step();
        drive(1'b0, 4'dx, 32'hxxxx_xxxx, 4'd7, 4'd5);
        expect_out(SEL_RD1, 32'h0, "disabled_r7_stays");
        expect_out(SEL_RD2, 32'h1234_5678, "disabled_x_r5_intact");
        step();
        drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd15);
        expect_out(SEL_RD1, 32'h0, "x_inputs_r7_intact");
        expect_out(SEL_RD2, 32'h0000_0104, "x_inputs_r15_intact");
        expect_out(SEL_CNT, 32'd3, "disabled_count");
        step();

        // overwrite sp, then reset with a competing write
        drive(1'b1, 4'd14, 32'h0000_AAAA, 4'd0, 4'd0);
        step();
        drive(1'b0, 4'd0, 32'h0, 4'd14, 4'd0);
        expect_out(SEL_RD1, 32'h0000_AAAA, "sp_written");
        expect_out(SEL_CNT, 32'd4, "sp_count");
        step();
        reset = 1'b1;
        drive(1'b1, 4'd14, 32'h0, 4'd14, 4'd3);
        step();
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 4'd14, 4'd3);
        expect_out(SEL_RD1, 32'h0000_FFFC, "reset_prio_sp");
        expect_out(SEL_RD2, 32'h0, "reset_clears_r3");
        expect_out(SEL_RA, 32'h0, "reset_clears_ra");
        expect_out(SEL_CNT, 32'h0, "reset_prio_count");
        step();

        // saturation run
        for (int i = 0; i < 16; i++) model[i] = (i == 14) ? 32'h0000_FFFC : 32'h0;
        for (int i = 0; i < 65540; i++) begin
            d = {i[15:0], ~i[15:0]};
            drive(1'b1, 4'(i), d, 4'(i + 1), 4'(i));
            if (i == 65534) expect_out(SEL_CNT, 32'h0000_FFFE, "count_ffe");
            if (i == 65535) expect_out(SEL_CNT, 32'h0000_FFFF, "count_fff");
            if (i == 65539) begin
                expect_out(SEL_CNT, 32'h0000_FFFF, "count_sat_hold");
                expect_out(SEL_RD2, WB_BYPASS ? d : model[i % 16], "sat_bypass");
                expect_out(SEL_RD1, model[(i + 1) % 16], "sat_rd1_prev");
            end
            model[i % 16] = d;
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'd0, 32'h0, 4'(2 * i), 4'(2 * i + 1));
            expect_out(SEL_RD1, model[2 * i], $sformatf("sat_r%0d", 2 * i));
            expect_out(SEL_RD2, model[2 * i + 1], $sformatf("sat_r%0d", 2 * i + 1));
            if (i == 0) begin
                expect_out(SEL_RA, model[15], "sat_ra");
                expect_out(SEL_CNT, 32'h0000_FFFF, "count_final");
            end
            step();
        end

        step();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file at the receiving end of the write-back interface. The WB stage drives the write port: enable, destination index and data; calls write r15.
- Serves two operand read ports to the operand-fetch stage. Also provides a dedicated return-address read for `ret`.
- Sequential write, combinational read, with optional same-cycle write-to-read bypass.

Parameters:
- NUM_REGS, 16, number of architectural registers; must be 2**ADDR_W.
- ADDR_W, 4, register index width.
- DATA_W, 32, register width.
- WB_BYPASS, 1, 1 = a read of the register being written this cycle returns the incoming write data; 0 = returns the stored value.
- SP_RESET, 32'h0000_FFFC, reset value of the stack pointer r14.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_en  in  1  write-back enable from WB stage.
- wb_addr  in  ADDR_W  destination index; WB drives 4'd15 for calls.
- wb_data  in  DATA_W  write data: ALU result, load data, or pc+4 for calls.
- rd_addr1  in  ADDR_W  read port 1 index (rs1).
- rd_addr2  in  ADDR_W  read port 2 index (rs2 or rd for store).
- rd_data1  out  DATA_W  read port 1 data.
- rd_data2  out  DATA_W  read port 2 data.
- ra_data  out  DATA_W  current r15 (return address), bypassed like the read ports.
- wr_count  out  16  saturating count of committed writes since reset (debug/verification).

Behaviour:
- Storage: NUM_REGS x DATA_W flops. Every register, including r0, is writable; there is no hardwired zero.
- Reset: the interface uses one clock; reset is synchronous and active-high.
  - When reset=1 at a rising edge: all registers := 0 except r14 := SP_RESET; wr_count := 0.
  - wb_en is ignored in a reset cycle; reset takes priority over writes.
  - The read outputs are combinational, so they show reset contents in the cycle after reset. A reset asserted mid-program discards all prior state in that edge.
- Write:
  - At a rising edge with reset=0 and wb_en=1, regs[wb_addr] := wb_data.
  - Write latency is 1 cycle: the value is visible from storage the cycle after the edge.
  - wb_en=0: no register changes, whatever wb_addr/wb_data hold. X on wb_addr/wb_data with wb_en=0 must not corrupt state.
- Read (combinational, zero latency):
  - rd_dataN = regs[rd_addrN], except when WB_BYPASS=1 && wb_en && wb_addr==rd_addrN, in which case rd_dataN = wb_data.
  - ra_data follows the same rule with index 15.
- Simultaneous events:
  - Both read ports may address the same register, including the one being written; both return identical data.
  - Reads never stall or block writes; there is exactly one write per cycle.
- wr_count increments by 1 on each committed write and saturates at 16'hFFFF; it does not wrap.
- There is no handshake. WB owns timing, and the file accepts one write every cycle.
- Widths: no sign or zero extension. Data passes through unmodified at DATA_W.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=4, REG_DATA_W=32, NUM_ARCH_REGS=16
  - RA_IDX=4'd15, SP_IDX=4'd14, SP_RESET_DEFAULT=32'h0000_FFFC
- WB and the decode stage import the same constants for the call destination and the stack pointer.
- One sub-module is natural: reg_file_bypass_mux. It is a pure combinational compare-and-select, instantiated three times (rd_data1, rd_data2, ra_data).
- Storage and the counter stay in the top.

Test Plan:
- Reset: hold reset 2 cycles, then read all 16 indices -> every read is 0 except r14 = 32'h0000_FFFC; wr_count = 0.
- Basic write/read: wb_en=1, wb_addr=3, wb_data=32'hDEAD_BEEF for one cycle, then rd_addr1=3 -> rd_data1 = 32'hDEAD_BEEF; wr_count = 1.
- Same-cycle bypass: wb_en=1, wb_addr=5, wb_data=32'h1234_5678 with rd_addr1=rd_addr2=5 -> both outputs read 32'h1234_5678 in that cycle when WB_BYPASS=1. With WB_BYPASS=0 they read the old r5 (0) that cycle and 32'h1234_5678 the next.
- Call write: wb_en=1, wb_addr=15, wb_data=32'h0000_0104 -> ra_data = 32'h0000_0104 the same cycle (bypass) and on every following cycle.
- Disabled write plus reset priority:
  - wb_en=0, wb_addr=7, wb_data=32'hFFFF_FFFF -> r7 stays 0.
  - reset=1 with wb_en=1, wb_addr=14, wb_data=32'h0 -> r14 = 32'h0000_FFFC after the edge and wr_count = 0.
- Counter saturation: force 65,540 consecutive writes -> wr_count stops at 16'hFFFF, and the register contents stay correct.
